// File: rtl/ofm_pkg.sv
// rtl/ofm_pkg.sv - shared widths, depth and FSM encoding for the OFM BRAM controller
package ofm_pkg;
    localparam int RAM_WIDTH = 64;
    localparam int RAM_DEPTH = 10;
    localparam int ADDR_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } ofm_state_t;
endpackage

// File: rtl/ofm_skid_buf.sv
// rtl/ofm_skid_buf.sv - 2-entry valid/ready output buffer with empty-path bypass
module ofm_skid_buf import ofm_pkg::*; #(
    parameter int W = RAM_WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         pop;

    // An arriving word goes straight out when nothing is buffered ahead of it.
    assign out_valid = (count != 2'd0) || in_valid;
    assign out_data  = (count == 2'd0 && in_valid) ? in_data : e0;
    assign pop       = out_valid && out_ready;

    // The producer never pushes into a full buffer unless a pop frees a slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid && !pop) begin
                        e0    <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        e0 <= in_data;
                    end else if (in_valid) begin
                        e1    <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        e0 <= e1;
                        if (in_valid) begin
                            e1 <= in_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/ofm_bram_ctrl.sv
// rtl/ofm_bram_ctrl.sv - frame controller: fill a single-port BRAM, then drain it in order
module ofm_bram_ctrl import ofm_pkg::*; #(
    parameter int RAM_WIDTH = ofm_pkg::RAM_WIDTH,
    parameter int RAM_DEPTH = ofm_pkg::RAM_DEPTH
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RAM_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_ena,
    output logic                 bram_wea,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    input  logic [RAM_WIDTH-1:0] bram_douta
);
    localparam logic [ADDR_W-1:0] DEPTH_CAP = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    ofm_state_t        state;
    ofm_state_t        state_next;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] out_cnt;
    logic              rd_all;
    logic              rd_inflight;
    logic [1:0]        buf_count;
    logic              accept;
    logic              wr_fire;
    logic              rd_fire;
    logic              pop;

    assign last_idx = len - ONE;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clka) begin
        if (!rsta) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        accept     = 1'b0;
        wr_fire    = 1'b0;
        rd_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && cfg_len != '0) begin
                    accept     = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_fire    = 1'b1;
                    bram_ena   = 1'b1;
                    bram_wea   = 1'b1;
                    bram_addra = wr_ptr;
                    bram_dina  = in_data;
                    if (wr_ptr == last_idx) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Reads in flight plus buffered words may never exceed the two buffer slots.
                if (!rd_all && (2'(rd_inflight) + buf_count - 2'(pop)) < 2'd2) begin
                    rd_fire    = 1'b1;
                    bram_ena   = 1'b1;
                    bram_addra = rd_ptr;
                end
                if (pop && out_cnt == last_idx) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rsta) begin
            len         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_cnt     <= '0;
            rd_all      <= 1'b0;
            rd_inflight <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            rd_inflight <= rd_fire;
            if (accept) begin
                len    <= (cfg_len > DEPTH_CAP) ? DEPTH_CAP : cfg_len;
                wr_ptr <= '0;
            end
            if (wr_fire) begin
                if (wr_ptr == last_idx) begin
                    rd_ptr  <= '0;
                    rd_all  <= 1'b0;
                    out_cnt <= '0;
                end else begin
                    wr_ptr <= wr_ptr + ONE;
                end
            end
            if (rd_fire) begin
                if (rd_ptr == last_idx) begin
                    rd_all <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + ONE;
                end
            end
            if (pop && state == ST_DRAIN) begin
                if (out_cnt == last_idx) begin
                    done <= 1'b1;
                end else begin
                    out_cnt <= out_cnt + ONE;
                end
            end
        end
    end

    ofm_skid_buf #(.W(RAM_WIDTH)) u_skid (
        .clk       (clka),
        .resetn    (rsta),
        .in_valid  (rd_inflight),
        .in_data   (bram_douta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (buf_count)
    );
endmodule

// File: tb/tb_ofm_bram_ctrl.sv
// tb/tb_ofm_bram_ctrl.sv - randomized frame bench for ofm_bram_ctrl against a frame-level model
module tb_ofm_bram_ctrl;
    localparam int W = 64;
    localparam int D = 10;

    logic         clka = 1'b0;
    logic         rsta;
    logic         start;
    logic [3:0]   cfg_len;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;
    logic         bram_ena;
    logic         bram_wea;
    logic [3:0]   bram_addra;
    logic [W-1:0] bram_dina;
    logic [W-1:0] bram_douta;
    logic [W-1:0] mem [0:15];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int or_mode = 0;

    logic [W-1:0] words [16];
    logic [W-1:0] out_q [$];
    logic [W-1:0] wr_d [$];
    int           pop_cyc [$];
    int           wr_a [$];
    int           rd_a [$];
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           first_rd = -1;
    int           last_wr  = -1;
    bit           stall_prev = 1'b0;
    logic [W-1:0] stall_data = '0;

    ofm_bram_ctrl dut (
        .clka       (clka),
        .rsta       (rsta),
        .start      (start),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addra] <= bram_dina;
            else          bram_douta <= mem[bram_addra];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clka) begin
        cyc++;
        if (bram_ena && bram_wea) begin
            wr_a.push_back(int'(bram_addra));
            wr_d.push_back(bram_dina);
            check_eq("wea_in_fill", in_ready, 1);
        end
        if (bram_ena && !bram_wea) begin
            rd_a.push_back(int'(bram_addra));
            if (first_rd < 0) first_rd = cyc;
        end
        if (in_valid && in_ready) last_wr = cyc;
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            pop_cyc.push_back(cyc);
        end
        if (stall_prev && rsta) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, stall_data);
        end
        stall_prev = out_valid && !out_ready && rsta;
        stall_data = out_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clka);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_obs();
        out_q.delete(); pop_cyc.delete(); wr_a.delete(); wr_d.delete(); rd_a.delete();
        done_cnt = 0; done_cyc = -1; first_rd = -1; last_wr = -1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom};
    endtask

    task automatic start_frame(input int cfg);
        @(posedge clka); #1;
        start = 1'b1;
        cfg_len = 4'(cfg);
        @(posedge clka); #1;
        start = 1'b0;
        cfg_len = 4'($urandom);
    endtask

    task automatic fill(input int n, input bit rnd);
        int k = 0;
        for (int g = 0; g < 400 && k < n; g++) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = words[k];
            @(negedge clka);
            if (in_valid && in_ready) k++;
            @(posedge clka); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        check_eq("fill_count", k, n);
    endtask

    task automatic wait_done();
        for (int g = 0; g < 300; g++) begin
            @(negedge clka); #1;
            if (done_cnt > 0) break;
        end
        check_eq("done_seen", done_cnt > 0, 1);
        repeat (3) @(negedge clka);
    endtask

    task automatic check_frame(input int eff);
        check_eq("n_writes", wr_a.size(), eff);
        check_eq("n_reads", rd_a.size(), eff);
        check_eq("n_out", out_q.size(), eff);
        check_eq("n_done", done_cnt, 1);
        for (int i = 0; i < eff; i++) begin
            if (i < wr_a.size()) begin
                check_eq("wr_addr", wr_a[i], i);
                check_eq("wr_data", wr_d[i], words[i]);
            end
            if (i < rd_a.size()) check_eq("rd_addr", rd_a[i], i);
            if (i < out_q.size()) check_eq("out_word", out_q[i], words[i]);
        end
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic run_frame(input int cfg, input int mode, input bit rnd);
        int eff;
        eff = (cfg > D) ? D : cfg;
        clear_obs();
        or_mode = mode;
        rand_words();
        start_frame(cfg);
        fill(eff, rnd);
        wait_done();
        check_frame(eff);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rsta = 1'b0; start = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; bram_douta = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ena", bram_ena, 0);
        check_eq("rst_wea", bram_wea, 0);
        check_eq("rst_addra", bram_addra, 0);
        check_eq("rst_dina", bram_dina, 0);
        rsta = 1'b1;

        // four words back to back, full-rate drain with exact latency
        clear_obs();
        or_mode = 0;
        for (int i = 0; i < 16; i++) words[i] = 64'(i + 1) * 64'h11;
        start_frame(4);
        fill(4, 1'b0);
        wait_done();
        check_frame(4);
        check_eq("first_rd_cyc", first_rd, last_wr + 1);
        for (int i = 0; i < 4; i++)
            if (i < pop_cyc.size()) check_eq("pop_cyc", pop_cyc[i], last_wr + 2 + i);
        check_eq("done_cyc", done_cyc, last_wr + 6);

        run_frame(10, 1, 1'b0);
        run_frame(15, 0, 1'b1);

        // zero length start is ignored
        clear_obs();
        start_frame(0);
        repeat (5) @(negedge clka);
        check_eq("zlen_busy", busy, 0);
        check_eq("zlen_access", wr_a.size() + rd_a.size(), 0);
        check_eq("zlen_done", done_cnt, 0);

        // extra start while filling must not disturb the frame
        clear_obs();
        or_mode = 2;
        rand_words();
        start_frame(5);
        start = 1'b1;
        cfg_len = 4'd3;
        @(posedge clka); #1;
        start = 1'b0;
        fill(5, 1'b1);
        wait_done();
        check_frame(5);

        // reset after the second drained word of six
        clear_obs();
        or_mode = 0;
        rand_words();
        start_frame(6);
        fill(6, 1'b0);
        for (int g = 0; g < 50; g++) begin
            @(negedge clka); #1;
            if (out_q.size() >= 2) break;
        end
        rsta = 1'b0;
        @(posedge clka); #1;
        @(negedge clka);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        rsta = 1'b1;
        repeat (5) @(negedge clka);
        check_eq("abort_done", done_cnt, 0);
        check_eq("abort_nout", out_q.size(), 2);
        for (int i = 0; i < 2; i++)
            if (i < out_q.size()) check_eq("abort_word", out_q[i], words[i]);
        run_frame(2, 0, 1'b1);

        // start in the done cycle is taken at once
        clear_obs();
        or_mode = 0;
        rand_words();
        start_frame(3);
        fill(3, 1'b0);
        for (int g = 0; g < 100; g++) begin
            @(negedge clka); #1;
            if (done) break;
        end
        check_eq("done_hit", done, 1);
        check_frame(3);
        start = 1'b1;
        cfg_len = 4'd2;
        clear_obs();
        rand_words();
        @(posedge clka); #1;
        start = 1'b0;
        @(negedge clka);
        check_eq("restart_busy", busy, 1);
        @(posedge clka); #1;
        fill(2, 1'b0);
        wait_done();
        check_frame(2);

        for (int r = 0; r < 4; r++) run_frame(int'($urandom_range(1, 15)), 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofm_bram_ctrl.md
OFM_BRAM_CTRL -- requirements
Module: ofm_bram_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 64, data word width.
REQ-002 Parameter RAM_DEPTH, default 10, BRAM entries; address width fixed at 4.
REQ-003 Port clka  in  1  sole clock; all logic on its rising edge.
REQ-004 Port rsta  in  1  reset; synchronous and active-low.
REQ-005 Port start  in  1  one-cycle frame start request.
REQ-006 Port cfg_len  in  4  words per frame, sampled on accepted start.
REQ-007 Port in_valid / in_ready / in_data  in / out / RAM_WIDTH  write-side handshake from accumulator.
REQ-008 Port out_valid / out_ready / out_data  out / in / RAM_WIDTH  drain-side handshake to output stream.
REQ-009 Port busy  out  1  high in FILL or DRAIN.
REQ-010 Port done  out  1  one-cycle pulse at frame completion.
REQ-011 Ports bram_ena, bram_wea  out  1 each; bram_addra  out  4; bram_dina  out  RAM_WIDTH; bram_douta  in  RAM_WIDTH  single-port BRAM, 1-cycle read latency, douta updates only on ena & !wea.

Function
REQ-012 FSM states IDLE, FILL, DRAIN; only IDLE accepts start.
REQ-013 IDLE: start=1, cfg_len!=0 -> latch len (saturated to RAM_DEPTH), wr_ptr=0, go FILL; cfg_len=0 -> start ignored, no done.
REQ-014 start outside IDLE and cfg_len changes after latch have no effect.
REQ-015 FILL: in_ready=1; each in_valid&in_ready cycle drives bram_ena=1, bram_wea=1, bram_addra=wr_ptr, bram_dina=in_data, then wr_ptr+1.
REQ-016 FILL: after len-th accepted write, next state DRAIN with rd_ptr=0; in_ready=0 from that next cycle.
REQ-017 in_ready=0 in IDLE and DRAIN; in_valid ignored there.
REQ-018 DRAIN: read issue drives bram_ena=1, bram_wea=0, bram_addra=rd_ptr, rd_ptr+1; at most len issues per frame.
REQ-019 Read issued in cycle t; word captured from bram_douta at t+1 into 2-entry output skid buffer.
REQ-020 Issue allowed only when (in-flight + buffered - pop_this_cycle) < 2; no word ever dropped or duplicated.
REQ-021 With out_ready held 1: first read in first DRAIN cycle, out_valid=1 one cycle later, then one word per cycle.
REQ-022 out_valid&!out_ready: out_valid and out_data held stable.
REQ-023 Words leave in address order 0..len-1.
REQ-024 len-th out_valid&out_ready -> done=1 next cycle, state IDLE, busy=0 same cycle.
REQ-025 bram_ena=0 whenever no write or read issued; bram_wea never 1 outside FILL.
REQ-026 start in same cycle as done asserted is accepted (IDLE already entered).
REQ-027 Pointers never exceed len-1; no wrap within a frame.

Reset
REQ-028 rsta=0 at an edge: state IDLE, pointers 0, skid buffer emptied, in-flight read discarded.
REQ-029 Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, bram_ena 0, bram_wea 0, bram_addra 0, bram_dina 0.
REQ-030 Reset mid-FILL or mid-DRAIN aborts frame without done; BRAM contents not cleared.

Structure
REQ-031 Shared package ofm_pkg holds RAM_WIDTH, RAM_DEPTH, ADDR_W=4, FSM state encoding.
REQ-032 One sub-module ofm_skid_buf (2-entry valid/ready buffer, sync active-low reset); FSM and pointers in ofm_bram_ctrl.
REQ-033 BRAM instantiated outside the block; bench connects the team's OFM BRAM in LOW_LATENCY mode.

Verification
REQ-034 Reset, start cfg_len=4, in_data 0x11..0x44 back-to-back, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, done 1 cycle after last.
REQ-035 cfg_len=10, out_ready toggles 1/0 each cycle -> 10 words in order, out_data stable while stalled, no loss.
REQ-036 cfg_len=15 -> exactly 10 writes (addr 0..9), 10 words out, done once.
REQ-037 cfg_len=0 start -> busy stays 0, no BRAM access, no done; start pulse during FILL -> ignored.
REQ-038 rsta=0 after 2nd drained word of 6 -> out_valid 0, busy 0 next cycle, no done; new frame cfg_len=2 completes correctly.
REQ-039 start on done cycle -> new frame accepted immediately, busy high next cycle.
